// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer: state encoding, prescale selects, default widths.
package timer_pkg;

  localparam int unsigned TMR_WIDTH = 8;
  localparam int unsigned TMR_PSC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    SWITCH = 2'd3
  } state_e;

  localparam logic [1:0] CKS_DIV2  = 2'b00;
  localparam logic [1:0] CKS_DIV4  = 2'b01;
  localparam logic [1:0] CKS_DIV8  = 2'b10;
  localparam logic [1:0] CKS_DIV16 = 2'b11;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for the timer: free-running psc with a sync clear, plus the
// latched prescale select cks_q.
// Ports:
//   pclk, presetn : clock, async active-low reset
//   clr           : synchronous clear of psc (wins over run)
//   run           : increment psc this cycle
//   cks_ld        : capture cks into cks_q
//   cks           : requested prescale select
//   cks_q         : prescale select currently in effect
//   term_c        : psc[cks_q:0] all ones (combinational)
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PSC_W = TMR_PSC_W
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       clr,
  input  logic       run,
  input  logic       cks_ld,
  input  logic [1:0] cks,
  output logic [1:0] cks_q,
  output logic       term_c
);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] mask_c;

  // Low cks_q+1 bits of psc participate in the terminal compare.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(PSC_W); i++) begin
      mask_c[i] = (i <= int'(cks_q));
    end
  end

  assign term_c = ((psc & mask_c) == mask_c);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psc   <= '0;
      cks_q <= CKS_DIV2;
    end else begin
      if (clr) begin
        psc <= '0;
      end else if (run) begin
        psc <= psc + PSC_W'(1);
      end
      if (cks_ld) begin
        cks_q <= cks;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing and counting controller for the 8-bit timer, single clock domain.
// Ports:
//   pclk, presetn    : clock, async active-low reset
//   en, updn         : count enable (level), direction (1 = up)
//   load, tdr        : load pulse and load value
//   cks              : prescale select (/2, /4, /8, /16)
//   clr_ovf, clr_udf : flag clear pulses
//   cnt, tick        : current count, one-cycle step pulse
//   ovf, udf         : sticky overflow / underflow flags
//   running          : high while in RUN
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TMR_WIDTH,
  parameter int unsigned PSC_W = TMR_PSC_W
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             en,
  input  logic             updn,
  input  logic             load,
  input  logic [1:0]       cks,
  input  logic [WIDTH-1:0] tdr,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             ovf,
  output logic             udf,
  output logic             running
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] cks_q;
  logic       term_c;
  logic       psc_run_c;
  logic       cks_ld_c;
  logic       step_c;
  logic       ovf_set_c;
  logic       udf_set_c;

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_psc (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (!psc_run_c),
    .run     (psc_run_c),
    .cks_ld  (cks_ld_c),
    .cks     (cks),
    .cks_q   (cks_q),
    .term_c  (term_c)
  );

  // Next state and per-cycle controls; load > en low > cks change.
  always_comb begin
    state_d   = state_q;
    psc_run_c = 1'b0;
    cks_ld_c  = 1'b0;
    step_c    = 1'b0;
    ovf_set_c = 1'b0;
    udf_set_c = 1'b0;

    if (load) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = RUN;
        LOAD:    state_d = en ? RUN : IDLE;
        RUN: begin
          if (!en)               state_d = IDLE;
          else if (cks != cks_q) state_d = SWITCH;
        end
        SWITCH:  state_d = en ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end

    // psc only advances while staying in RUN, so any exit drops a due tick
    // and every entry into RUN starts a full period from psc = 0.
    psc_run_c = (state_q == RUN) && (state_d == RUN);
    cks_ld_c  = (state_q == SWITCH) || ((state_q != RUN) && (state_d == RUN));
    step_c    = psc_run_c && term_c;
    ovf_set_c = step_c && updn && (cnt == '1);
    udf_set_c = step_c && !updn && (cnt == '0);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt     <= '0;
      tick    <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == LOAD) begin
        cnt <= tdr;
      end else if (step_c) begin
        cnt <= updn ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
      end
      tick    <= step_c;
      // Set wins over a simultaneous clear.
      ovf     <= ovf_set_c | (ovf & ~clr_ovf);
      udf     <= udf_set_c | (udf & ~clr_udf);
      running <= (state_d == RUN);
    end
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing and counting controller for the 8-bit timer. Replaces the ripple-divided prescaler clocks with a single-clock design.
- Runs entirely on pclk. A 4-bit prescale counter generates one-cycle tick enables at pclk/2, /4, /8 or /16, selected by cks.
- Drives an 8-bit up/down counter with load, overflow and underflow flags.
- Handles a cks change mid-run safely: no runt or double ticks.
- Sits between the register block (which supplies TCR/TDR fields) and the interrupt logic (which consumes the flags).

Parameters:
- WIDTH, 8, counter and load-data width.
- PSC_W, 4, prescale counter width; supports divide-by 2^(cks+1).

Ports:
- pclk  input  1  system clock; all logic posedge pclk.
- presetn  input  1  asynchronous active-low reset.
- en  input  1  count enable (level).
- updn  input  1  direction: 1 = up, 0 = down.
- load  input  1  single-cycle pulse: load tdr into counter.
- cks  input  2  prescale select: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- tdr  input  WIDTH  load value.
- clr_ovf  input  1  pulse: clear ovf.
- clr_udf  input  1  pulse: clear udf.
- cnt  output  WIDTH  current count.
- tick  output  1  one-cycle pulse when the counter steps.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.
- running  output  1  high while state = RUN.

Behaviour:
- Reset (presetn=0, asynchronous):
  - state=IDLE, cnt=0, psc=0, cks_q=00, tick=0, ovf=0, udf=0, running=0.
- States: IDLE, LOAD, RUN, SWITCH. Transition priority, highest first: reset > load > en deasserted > cks change.
- IDLE:
  - psc held at 0; cnt holds.
  - load=1 -> LOAD.
  - else en=1 -> RUN, with cks_q<=cks.
- LOAD (one cycle):
  - Entering LOAD: cnt<=tdr and psc<=0 on the same edge.
  - Next state: RUN if en=1 (cks_q<=cks), else IDLE.
  - load in any state goes to LOAD.
- RUN:
  - psc increments every cycle.
  - Terminal condition: psc[cks_q:0] all ones. At terminal, tick=1 in the following cycle, registered with the cnt update, and psc keeps free-running.
  - Tick period is exactly 2^(cks_q+1) pclk. The first tick occurs 2^(cks_q+1) cycles after RUN is entered.
  - en=0 -> IDLE, psc<=0. A tick already due on that edge is dropped.
  - cks != cks_q (and no load) -> SWITCH. No tick on that edge.
- SWITCH (one cycle):
  - psc<=0, cks_q<=cks, no counting.
  - Then RUN if en=1, else IDLE.
  - The first tick after a switch arrives 2^(new+1) cycles after re-entering RUN.
- Count step, on each tick:
  - updn=1: cnt<=cnt+1. If cnt==2^WIDTH-1, cnt wraps to 0 and ovf<=1.
  - updn=0: cnt<=cnt-1. If cnt==0, cnt wraps to all-ones and udf<=1.
  - updn is sampled on the tick edge; changing it mid-period is legal.
- Flags:
  - Sticky; cleared only by clr_ovf / clr_udf.
  - Set and clear in the same cycle: set wins.
  - load does not affect the flags.
- Outputs are registered. running = (state==RUN).
- Reset asserted mid-count: everything returns immediately to the reset values above; there is no partial tick.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding typedef (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, SWITCH=2'd3);
  - CKS_DIV2..CKS_DIV16 constants;
  - WIDTH default.
- One sub-module, timer_prescaler:
  - holds psc and cks_q and produces the terminal pulse;
  - controls: clr (sync clear), run.
- The FSM, counter and flags stay in timer_ctrl.

Test Plan:
- Reset, then load pulse with tdr=8'hFD, en=1, updn=1, cks=00 -> cnt=FD; ticks every 2 cycles; cnt FE, FF, 00 with ovf=1 on the FF->00 tick; ovf stays 1 until clr_ovf.
- tdr=8'h01, updn=0, cks=11 -> tick period 16 pclk; cnt 01 -> 00 -> FF; udf=1 at the FF step.
- Running at cks=11, change cks to 00 eight cycles into a period -> one SWITCH cycle with no tick; next tick exactly 2 cycles after RUN resumes, then every 2 cycles.
- clr_ovf asserted on the same cycle as an FF->00 tick -> ovf remains 1; clr_ovf on a later cycle -> ovf=0.
- en dropped for 5 cycles mid-period at cks=01 -> cnt frozen, running=0; on re-enable, first tick after 4 cycles.
- presetn pulsed low mid-RUN with cnt=8'h42 -> cnt=0, flags 0, running=0 immediately (asynchronously); no tick for 2^(cks+1) cycles after en is reasserted.
